// File: rtl/lcd_spi_sink.sv
// -----------------------------------------------------------------------------
// lcd_spi_sink
// Receive-side model of the ST7735 SPI write path. Oversamples the panel pins
// in the sys_clk domain, rebuilds {dc, byte} words and decodes the
// CASET / RASET / RAMWR subset into addressed RGB565 pixel writes.
//
// Ports
//   sys_clk, sys_rst_n        : only clock; async active-low reset
//   cs, dc, sclk, mosi        : raw panel pins (asynchronous to sys_clk)
//   byte_valid/data/dc        : one-cycle pulse per received byte, data held
//   cmd_valid/cmd_code        : one-cycle pulse per command byte, code held
//   pix_valid/data/x/y        : one-cycle pulse per completed pixel, held
// -----------------------------------------------------------------------------
module lcd_spi_sink #(
    parameter logic [7:0] XMAX = 8'd127,
    parameter logic [7:0] YMAX = 8'd159
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cs,
    input  logic        dc,
    input  logic        sclk,
    input  logic        mosi,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_RASET = 2'd2,
        ST_RAMWR = 2'd3
    } state_t;

    // ---------------- input conditioning ----------------
    logic r_cs_meta, r_cs_sync;
    logic r_dc_meta, r_dc_sync;
    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic r_mosi_meta, r_mosi_sync;
    logic w_sclk_rise;

    // Identical 2-FF synchronizers keep the relative order of the four pins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_dc_meta   <= 1'b0;
            r_dc_sync   <= 1'b0;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_cs_meta   <= cs;
            r_cs_sync   <= r_cs_meta;
            r_dc_meta   <= dc;
            r_dc_sync   <= r_dc_meta;
            r_sclk_meta <= sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_sclk_rise = r_sclk_sync & ~r_sclk_d;

    // ---------------- bit assembly ----------------
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;

    // Shift on each sclk rise while selected; deselect drops a partial byte.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_shift    <= 8'h00;
            r_bit_cnt  <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (r_cs_sync) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[6:0], r_mosi_sync};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {r_shift[6:0], r_mosi_sync};
                    byte_dc    <= r_dc_sync;
                end
            end
        end
    end

    // ---------------- command / pixel decoder ----------------
    state_t     r_state, w_state_nxt;
    logic [1:0] r_pidx, w_pidx_nxt;
    logic       r_pdone, w_pdone_nxt;   // all four parameters consumed
    logic       r_hp, w_hp_nxt;
    logic [7:0] r_hi, w_hi_nxt;
    logic [7:0] r_xs, w_xs_nxt, r_xe, w_xe_nxt;
    logic [7:0] r_ys, w_ys_nxt, r_ye, w_ye_nxt;
    logic [7:0] r_cx, w_cx_nxt, r_cy, w_cy_nxt;
    logic       w_cmd_valid_nxt, w_pix_valid_nxt;
    logic [7:0] w_cmd_code_nxt;
    logic [15:0] w_pix_data_nxt;
    logic [7:0] w_pix_x_nxt, w_pix_y_nxt;

    // Decoder state and all registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_pidx    <= 2'd0;
            r_pdone   <= 1'b0;
            r_hp      <= 1'b0;
            r_hi      <= 8'h00;
            r_xs      <= 8'h00;
            r_xe      <= XMAX;
            r_ys      <= 8'h00;
            r_ye      <= YMAX;
            r_cx      <= 8'h00;
            r_cy      <= 8'h00;
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
            pix_valid <= 1'b0;
            pix_data  <= 16'h0000;
            pix_x     <= 8'h00;
            pix_y     <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_pidx    <= w_pidx_nxt;
            r_pdone   <= w_pdone_nxt;
            r_hp      <= w_hp_nxt;
            r_hi      <= w_hi_nxt;
            r_xs      <= w_xs_nxt;
            r_xe      <= w_xe_nxt;
            r_ys      <= w_ys_nxt;
            r_ye      <= w_ye_nxt;
            r_cx      <= w_cx_nxt;
            r_cy      <= w_cy_nxt;
            cmd_valid <= w_cmd_valid_nxt;
            cmd_code  <= w_cmd_code_nxt;
            pix_valid <= w_pix_valid_nxt;
            pix_data  <= w_pix_data_nxt;
            pix_x     <= w_pix_x_nxt;
            pix_y     <= w_pix_y_nxt;
        end
    end

    // Next-state decode of each received byte.
    always_comb begin
        w_state_nxt     = r_state;
        w_pidx_nxt      = r_pidx;
        w_pdone_nxt     = r_pdone;
        w_hp_nxt        = r_hp;
        w_hi_nxt        = r_hi;
        w_xs_nxt        = r_xs;
        w_xe_nxt        = r_xe;
        w_ys_nxt        = r_ys;
        w_ye_nxt        = r_ye;
        w_cx_nxt        = r_cx;
        w_cy_nxt        = r_cy;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_code_nxt  = cmd_code;
        w_pix_valid_nxt = 1'b0;
        w_pix_data_nxt  = pix_data;
        w_pix_x_nxt     = pix_x;
        w_pix_y_nxt     = pix_y;

        if (byte_valid) begin
            if (!byte_dc) begin
                w_cmd_valid_nxt = 1'b1;
                w_cmd_code_nxt  = byte_data;
                w_pidx_nxt      = 2'd0;
                w_pdone_nxt     = 1'b0;
                w_hp_nxt        = 1'b0;
                case (byte_data)
                    8'h2A:   w_state_nxt = ST_CASET;
                    8'h2B:   w_state_nxt = ST_RASET;
                    8'h2C: begin
                        w_state_nxt = ST_RAMWR;
                        w_cx_nxt    = r_xs;
                        w_cy_nxt    = r_ys;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end else begin
                case (r_state)
                    ST_CASET, ST_RASET: begin
                        if (!r_pdone) begin
                            // Even indices are high bytes; panel fits in 8 bits.
                            if (r_pidx == 2'd1) begin
                                if (r_state == ST_CASET) w_xs_nxt = byte_data;
                                else                     w_ys_nxt = byte_data;
                            end else if (r_pidx == 2'd3) begin
                                if (r_state == ST_CASET) w_xe_nxt = byte_data;
                                else                     w_ye_nxt = byte_data;
                                w_pdone_nxt = 1'b1;
                            end else begin
                                w_pdone_nxt = r_pdone;
                            end
                            w_pidx_nxt = r_pidx + 2'd1;
                        end else begin
                            w_pidx_nxt = r_pidx;
                        end
                    end
                    ST_RAMWR: begin
                        if (!r_hp) begin
                            w_hi_nxt = byte_data;
                            w_hp_nxt = 1'b1;
                        end else begin
                            w_pix_valid_nxt = 1'b1;
                            w_pix_data_nxt  = {r_hi, byte_data};
                            w_pix_x_nxt     = r_cx;
                            w_pix_y_nxt     = r_cy;
                            w_hp_nxt        = 1'b0;
                            // Equality-only compares: an inverted window wraps mod 256.
                            if (r_cx == r_xe) begin
                                w_cx_nxt = r_xs;
                                if (r_cy == r_ye) w_cy_nxt = r_ys;
                                else              w_cy_nxt = r_cy + 8'd1;
                            end else begin
                                w_cx_nxt = r_cx + 8'd1;
                            end
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
        end else if (r_cs_sync) begin
            // Deselect drops a dangling half pixel but stays in RAMWR.
            w_hp_nxt = 1'b0;
        end else begin
            w_hp_nxt = r_hp;
        end
    end

endmodule
